// File: rtl/uart_frame_ctrl.sv
// Frame sequencer for the UART receive stream: SYNC, CMD, LEN, payload, CSUM.
// Payload bytes are staged as they arrive; the command is offered only after the checksum passes.
module uart_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_break,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_op,
   output logic [4:0] cmd_len,
   output logic       busy,
   output logic       err_csum,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic [7:0] frame_cnt
);

   localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_ISSUE
   } state_t;

   state_t          state;
   logic [7:0]      sum;
   logic [7:0]      op_q;
   logic [4:0]      len_q;
   logic [3:0]      idx;
   logic [TW-1:0]   tcnt;
   logic [7:0]      sum_next;
   logic            tmo_hit;

   assign sum_next = sum + rx_data;
   // Fire on the edge where the counter would reach TIMEOUT_CYCLES-1.
   assign tmo_hit  = (tcnt == TW'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         sum         <= '0;
         op_q        <= '0;
         len_q       <= '0;
         idx         <= '0;
         tcnt        <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         cmd_valid   <= 1'b0;
         cmd_op      <= '0;
         cmd_len     <= '0;
         busy        <= 1'b0;
         err_csum    <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         wr_en       <= 1'b0;
         err_csum    <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         case (state)
            S_IDLE: begin
               tcnt <= '0;
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state <= S_CMD;
                  busy  <= 1'b1;
               end
            end
            S_ISSUE: begin
               tcnt <= '0;
               if (rx_valid) err_overrun <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  frame_cnt <= frame_cnt + 8'd1;
                  cmd_valid <= 1'b0;
                  state     <= S_IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               // In-frame states: break beats a byte, a byte beats the timeout.
               if (rx_break) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  tcnt  <= '0;
               end else if (rx_valid) begin
                  tcnt <= '0;
                  case (state)
                     S_CMD: begin
                        op_q  <= rx_data;
                        sum   <= rx_data;
                        state <= S_LEN;
                     end
                     S_LEN: begin
                        sum <= sum_next;
                        if (rx_data > MAX_LEN_B) begin
                           err_len <= 1'b1;
                           state   <= S_IDLE;
                           busy    <= 1'b0;
                        end else if (rx_data == 8'd0) begin
                           len_q <= '0;
                           state <= S_CSUM;
                        end else begin
                           len_q <= rx_data[4:0];
                           idx   <= '0;
                           state <= S_PAYLOAD;
                        end
                     end
                     S_PAYLOAD: begin
                        sum     <= sum_next;
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= rx_data;
                        idx     <= idx + 4'd1;
                        if ({1'b0, idx} == len_q - 5'd1) state <= S_CSUM;
                     end
                     S_CSUM: begin
                        if (sum_next == 8'd0) begin
                           cmd_valid <= 1'b1;
                           cmd_op    <= op_q;
                           cmd_len   <= len_q;
                           state     <= S_ISSUE;
                        end else begin
                           err_csum <= 1'b1;
                           state    <= S_IDLE;
                           busy     <= 1'b0;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end else if (tmo_hit) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  tcnt        <= '0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames plus random frames, checked against
// expectations computed from whole-frame arithmetic and a staged-write scoreboard.
module tb_uart_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_break = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       wr_en, cmd_valid, busy;
   logic       err_csum, err_len, err_timeout, err_overrun;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, cmd_op, frame_cnt;
   logic [4:0] cmd_len;

   int checks = 0;
   int errors = 0;
   int n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
   int exp_csum = 0, exp_len = 0, exp_tmo = 0, exp_ovr = 0;
   logic [7:0]  exp_frames = 8'd0;
   logic [11:0] exp_q[$];
   logic [7:0]  fb[$];

   uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .busy(busy), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
      .err_overrun(err_overrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Staging writes are popped against the expected queue; error pulses are tallied.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) chk("wr_unexpected", {20'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            else chk("wr_scoreboard", {20'h0, wr_addr, wr_data}, {20'h0, exp_q.pop_front()});
         end
         n_csum += int'(err_csum);
         n_len  += int'(err_len);
         n_tmo  += int'(err_timeout);
         n_ovr  += int'(err_overrun);
      end
   end

   // All drive tasks start and end 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic run_frame(input bit ready);
      int n;
      int len;
      int sum;
      n   = fb.size();
      len = (n > 2) ? int'(fb[2]) : 0;
      sum = 0;
      cmd_ready = ready;
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, 3));
         if (i >= 3 && len <= MAX_LEN && i < 3 + len) exp_q.push_back({4'(i - 3), fb[i]});
         if (i >= 1) sum += int'(fb[i]);
         send_byte(fb[i]);
         if (i == 0) begin
            chk("busy_rise", busy, 1);
            chk("no_wr_sync", wr_en, 0);
         end else if (i == 2 && len > MAX_LEN) begin
            chk("err_len", err_len, 1);
            chk("busy_after_len", busy, 0);
            exp_len++;
         end else if (i >= 3 && i < 3 + len) begin
            chk("wr_en_lat", wr_en, 1);
            chk("wr_addr", wr_addr, i - 3);
            chk("wr_data", wr_data, fb[i]);
         end else if (i == 3 + len) begin
            if (sum % 256 == 0) begin
               chk("cmd_valid_rise", cmd_valid, 1);
               chk("cmd_op", cmd_op, fb[1]);
               chk("cmd_len", cmd_len, len);
            end else begin
               chk("err_csum", err_csum, 1);
               chk("cmd_valid_bad", cmd_valid, 0);
               chk("busy_after_csum", busy, 0);
               exp_csum++;
            end
         end
      end
      if (n == 4 + len && sum % 256 == 0 && ready) begin
         idle(1);
         exp_frames++;
         chk("cmd_valid_drop", cmd_valid, 0);
         chk("frame_cnt", frame_cnt, exp_frames);
         chk("busy_after_issue", busy, 0);
      end
   endtask

   task automatic set_good();
      fb = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCA};
   endtask

   initial begin
      // Asynchronous reset, observed before any clock edge.
      #3 rst = 1'b1;
      #1;
      chk("rst_outputs", {wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy,
                          err_csum, err_len, err_timeout, err_overrun, frame_cnt}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Garbage in IDLE is ignored.
      send_byte(8'h00); chk("garbage_busy0", busy, 0);
      send_byte(8'hFF); chk("garbage_busy1", busy, 0);
      send_byte(8'hA4); chk("garbage_busy2", busy, 0);

      set_good(); run_frame(1);
      fb = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCB}; run_frame(1);
      chk("frame_cnt_after_bad", frame_cnt, exp_frames);
      set_good(); run_frame(1);

      fb = '{8'hA5, 8'h07, 8'h11}; run_frame(1);
      fb = '{8'hA5, 8'h07, 8'h00, 8'hF9}; run_frame(1);

      // Backpressure with an overrun byte during ISSUE.
      set_good(); run_frame(0);
      for (int c = 0; c < 20; c++) begin
         if (c == 7) begin
            send_byte(8'h55);
            chk("err_overrun", err_overrun, 1);
            exp_ovr++;
         end else begin
            idle(1);
            chk("no_overrun", err_overrun, 0);
         end
         chk("bp_valid", cmd_valid, 1);
         chk("bp_op_len", {cmd_op, 3'b000, cmd_len}, {8'h01, 8'h02});
      end
      cmd_ready = 1'b1;
      idle(1);
      exp_frames++;
      chk("bp_drop", cmd_valid, 0);
      chk("bp_frame_cnt", frame_cnt, exp_frames);

      // Inter-byte timeout, counted in edges from the last accepted byte.
      send_byte(8'hA5);
      send_byte(8'h01);
      for (int k = 1; k <= TMO; k++) begin
         idle(1);
         if (k == TMO - 2) chk("tmo_early", {err_timeout, busy}, 2'b01);
         if (k == TMO - 1) chk("tmo_pulse", {err_timeout, busy}, 2'b10);
         if (k == TMO)     chk("tmo_after", {err_timeout, busy}, 2'b00);
      end
      exp_tmo++;

      // Break mid-payload, with a coincident byte that must be discarded.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
      exp_q.push_back({4'd0, 8'h11});
      send_byte(8'h11);
      rx_break = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h22;
      @(posedge clk); #1;
      rx_break = 1'b0;
      rx_valid = 1'b0;
      chk("break_idle", {busy, wr_en, err_csum, err_len, err_timeout, err_overrun}, 0);
      set_good(); run_frame(1);

      // Asynchronous reset mid-payload.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
      exp_q.push_back({4'd0, 8'h11});
      send_byte(8'h11);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {wr_en, wr_addr, wr_data, cmd_valid, cmd_op, cmd_len, busy,
                              err_csum, err_len, err_timeout, err_overrun, frame_cnt}, 0);
      exp_frames = 8'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      set_good(); run_frame(1);

      // Random frames: lengths across the legal range and beyond, some corrupted sums.
      for (int r = 0; r < 12; r++) begin
         logic [7:0] op, len, csum;
         int s;
         op  = 8'($urandom);
         len = 8'($urandom_range(0, MAX_LEN + 2));
         fb  = '{8'hA5, op, len};
         if (len <= MAX_LEN) begin
            s = int'(op) + int'(len);
            for (int p = 0; p < int'(len); p++) begin
               fb.push_back(8'($urandom));
               s += int'(fb[fb.size() - 1]);
            end
            csum = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 3) == 0) csum = csum ^ 8'h01;
            fb.push_back(csum);
         end
         run_frame(1);
      end

      idle(2);
      chk("tot_err_csum", n_csum, exp_csum);
      chk("tot_err_len", n_len, exp_len);
      chk("tot_err_timeout", n_tmo, exp_tmo);
      chk("tot_err_overrun", n_ovr, exp_ovr);
      chk("wr_left_over", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
